hazard_sequencer: RTL and testbench
===================================

# hazard_sequencer

Pipeline hazard and stall sequencer for the 5-stage RV32I core. It consumes the ID-stage decode flags from the instruction decoder (`branch_flag`, `branch_or_jalr`), the EX/MEM destination and memory-read state, and the busy flags of the IM/DM AXI master wrappers. It drives the write-enables and flush controls of the PC and the four pipeline registers. It sequences load-use stalls, the 1–2 cycle branch/JALR operand stalls, ID-stage redirects and global freezes on memory wait, and it keeps hazard performance counters.

## Interface
Parameters:
- `CNT_W`, default 32: performance counter width.

Ports (reset is synchronous, active-high; one clock):
- `clk` in 1: core clock.
- `rst` in 1: synchronous active-high reset.
- `id_rs1`, `id_rs2` in 5 each: source register indices of the ID instruction.
- `id_rs1_use`, `id_rs2_use` in 1 each: the ID instruction reads rs1 / rs2.
- `id_branch_or_jalr` in 1: ID instruction is a branch or JALR, so it reads registers in ID.
- `id_redirect` in 1: the ID stage resolved a taken branch or jump this cycle.
- `ex_rd` in 5, `ex_regwrite` in 1, `ex_memread` in 1: state of the instruction in EX.
- `mem_rd` in 5, `mem_memread` in 1: state of the instruction in MEM.
- `im_stall`, `dm_stall` in 1 each: IM/DM AXI transaction outstanding.
- `perf_clr` in 1: synchronous clear of the counters.
- `pc_write`, `ifid_write`, `idex_write`, `exmem_write`, `memwb_write` out 1 each: register update enables.
- `ifid_flush`, `idex_flush` out 1 each: load a NOP/bubble.
- `cyc_cnt`, `stall_cnt`, `freeze_cnt`, `flush_cnt` out `CNT_W` each: performance counters.

## Operation
- freeze = `im_stall | dm_stall`.
  - All five write-enables are 0 and both flushes are 0.
  - FSM state is held and no hazard is evaluated.
- Register match: a source matches when rd ≠ 0, the rd equals the source index, and the corresponding `_use` bit is 1.
- Hazard rules, evaluated only in state RUN when not frozen:
  - LU: `ex_memread` and the EX rd matches → 1 stall.
  - BR_EX: `id_branch_or_jalr`, `ex_regwrite` and the EX rd matches → 1 stall if `!ex_memread`, 2 stalls if `ex_memread`.
  - BR_MEM: `id_branch_or_jalr`, `mem_memread` and the MEM rd matches → 1 stall.
- Stall cycle outputs: `pc_write`=0, `ifid_write`=0, `idex_flush`=1, `idex_write`=`exmem_write`=`memwb_write`=1, `ifid_flush`=0.
- FSM states are RUN and STALL2.
  - RUN → STALL2 when BR_EX with `ex_memread` is detected; that cycle is the first stall.
  - STALL2 unconditionally outputs a stall cycle and then returns to RUN.
  - A freeze while in STALL2 holds STALL2.
- Redirect: accepted only in RUN, not frozen and with no hazard.
  - Outputs: `ifid_flush`=1 and all writes 1 (PC takes the target selected in ID).
  - When `id_redirect` coincides with a hazard, the stall wins and the redirect is not counted. ID re-resolves the redirect after the stall.
- Normal cycle: all writes 1 and both flushes 0.
- Counters (all wrap at 2^`CNT_W`):
  - `cyc_cnt` +1 every cycle.
  - `stall_cnt` +1 per stall cycle.
  - `freeze_cnt` +1 per freeze cycle.
  - `flush_cnt` +1 per accepted redirect.
  - `perf_clr` zeroes all four and wins over an increment in the same cycle.

## Timing
- Control outputs are combinational from inputs and the state, and are valid in the same cycle. Only the state and counters are registered.
- While `rst`=1: `pc_write`=`ifid_write`=`idex_write`=`exmem_write`=`memwb_write`=0 and `ifid_flush`=`idex_flush`=1.
- After the reset edge: state RUN and all counters 0.
- Reset asserted in STALL2 → RUN on the next edge, and the pending stall is dropped.
- Load→dependent branch totals exactly 2 stall cycles: the detection cycle plus STALL2. In the following RUN cycle the load is in WB, and the register file write-through covers the read.
- A freeze arriving mid-stall extends it but never shortens it. The stall count is the number of non-frozen stall cycles.
- Simultaneous `im_stall` and `dm_stall`: one freeze cycle is counted.

## Structure
- `hazard_pkg` holds:
  - enum `hz_state_e` {RUN, STALL2};
  - localparam `REG_X0` = 5'd0;
  - a packed struct `pipe_ctrl_t` bundling the seven control outputs.
- `hazard_perf_cnt` is a sub-module: one instance per counter, with `clk`, `rst`, `clr`, `inc` and `cnt`, parameterised by `CNT_W`.

## Test plan
- Load-use hazard: `ex_memread`=1, `ex_rd`=5, `id_rs1`=5, `id_rs1_use`=1 → exactly 1 cycle with `pc_write`=0 and `idex_flush`=1, then normal; `stall_cnt`=1.
- Branch after ALU op: `id_branch_or_jalr`=1, `ex_regwrite`=1, `ex_memread`=0, `ex_rd`=`id_rs2`=7 → 1 stall cycle.
- Branch after load: same with `ex_memread`=1, and on the next cycle MEM holds the load → 2 consecutive stall cycles and no third; `stall_cnt`=2.
- Redirect with freeze: `id_redirect`=1 while `im_stall`=1 for 3 cycles → 3 freeze cycles with all writes 0, then 1 cycle with `ifid_flush`=1; `freeze_cnt`=3, `flush_cnt`=1.
- x0 write: `ex_rd`=0 with matching x0 sources → no stall.
- Reset in STALL2, then `perf_clr` coincident with a stall → state RUN next cycle and counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM state, the bundled
// pipeline control word and the source/destination match rule.
package hazard_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    STALL2 = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic memwb_write;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_REDIR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  // x0 is never a real producer, so it can never create a dependency.
  function automatic logic rd_match(input logic [4:0] rd,
                                    input logic [4:0] src,
                                    input logic       src_used);
    return src_used && (rd != REG_X0) && (rd == src);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Wrapping performance counter with synchronous clear; clear beats increment.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Load-use / branch-operand stall sequencer, ID redirect and memory-wait
// freeze control for the 5-stage RV32I pipeline, plus hazard counters.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_use,
  input  logic             id_rs2_use,
  input  logic             id_branch_or_jalr,
  input  logic             id_redirect,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_memread,
  input  logic             im_stall,
  input  logic             dm_stall,
  input  logic             perf_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_e  state_q;
  hz_state_e  state_d;
  pipe_ctrl_t ctrl;

  logic freeze;
  logic ex_match;
  logic mem_match;
  logic hz_lu;
  logic hz_br_ex;
  logic hz_br_mem;
  logic hazard;
  logic stall_cycle;
  logic redirect_acc;

  assign freeze    = im_stall | dm_stall;
  assign ex_match  = rd_match(ex_rd, id_rs1, id_rs1_use) | rd_match(ex_rd, id_rs2, id_rs2_use);
  assign mem_match = rd_match(mem_rd, id_rs1, id_rs1_use) | rd_match(mem_rd, id_rs2, id_rs2_use);

  assign hz_lu     = ex_memread & ex_match;
  assign hz_br_ex  = id_branch_or_jalr & ex_regwrite & ex_match;
  assign hz_br_mem = id_branch_or_jalr & mem_memread & mem_match;
  assign hazard    = hz_lu | hz_br_ex | hz_br_mem;

  // Hazards are only looked at in RUN; STALL2 is a committed second bubble.
  assign stall_cycle  = !rst && !freeze && ((state_q == STALL2) || hazard);
  assign redirect_acc = !rst && !freeze && (state_q == RUN) && !hazard && id_redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!freeze) begin
      case (state_q)
        RUN:     if (hz_br_ex && ex_memread) state_d = STALL2;
        STALL2:  state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_NORMAL;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
    end else if (stall_cycle) begin
      ctrl = CTRL_STALL;
    end else if (redirect_acc) begin
      ctrl = CTRL_REDIR;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_write  = ctrl.idex_write;
  assign exmem_write = ctrl.exmem_write;
  assign memwb_write = ctrl.memwb_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(1'b1), .cnt(cyc_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(stall_cycle), .cnt(stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(freeze), .cnt(freeze_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(redirect_acc), .cnt(flush_cnt)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed scenarios plus random
// traffic checked against a stall-budget reference model.
module tb_hazard_sequencer;

  localparam int CNT_W = 8;
  localparam int MASK  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd, mem_rd;
  logic             id_rs1_use, id_rs2_use, id_branch_or_jalr, id_redirect;
  logic             ex_regwrite, ex_memread, mem_memread;
  logic             im_stall, dm_stall, perf_clr;
  logic             pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic             ifid_flush, idex_flush;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, freeze_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_branch_or_jalr(id_branch_or_jalr), .id_redirect(id_redirect),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_memread(mem_memread),
    .im_stall(im_stall), .dm_stall(dm_stall), .perf_clr(perf_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       rs1_use, rs2_use, br, redirect;
    logic [4:0] ex_rd;
    logic       ex_regwrite, ex_memread;
    logic [4:0] mem_rd;
    logic       mem_memread, im, dm, clr;
  } stim_t;

  typedef struct {
    string tag;
    int    cyc;
    logic [6:0] ctrl;
    bit    cnt_valid;
    int    c_cyc, c_stall, c_freeze, c_flush;
  } exp_t;

  localparam logic [6:0] E_NORMAL = 7'b1111100;
  localparam logic [6:0] E_STALL  = 7'b0011101;
  localparam logic [6:0] E_REDIR  = 7'b1111110;
  localparam logic [6:0] E_FREEZE = 7'b0000000;
  localparam logic [6:0] E_RESET  = 7'b0000011;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle_no = 0;

  // Reference model: a budget of owed bubbles rather than named states.
  int  owed = 0;
  bit  cnt_known = 0;
  int  m_cyc = 0, m_stall = 0, m_freeze = 0, m_flush = 0;

  function automatic bit dep(input logic [4:0] rd, input logic [4:0] src, input logic u);
    return u && rd != 0 && rd == src;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic drive(input stim_t s, input string tag);
    exp_t e;
    int   need;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rs1_use = s.rs1_use; id_rs2_use = s.rs2_use;
    id_branch_or_jalr = s.br; id_redirect = s.redirect;
    ex_rd = s.ex_rd; ex_regwrite = s.ex_regwrite; ex_memread = s.ex_memread;
    mem_rd = s.mem_rd; mem_memread = s.mem_memread;
    im_stall = s.im; dm_stall = s.dm; perf_clr = s.clr;

    e.tag = tag; e.cyc = cycle_no; e.cnt_valid = cnt_known;
    e.c_cyc = m_cyc; e.c_stall = m_stall; e.c_freeze = m_freeze; e.c_flush = m_flush;
    cycle_no++;

    if (s.rst) begin
      e.ctrl = E_RESET;
      owed = 0;
      cnt_known = 1;
      m_cyc = 0; m_stall = 0; m_freeze = 0; m_flush = 0;
      exp_q.push_back(e);
      return;
    end

    m_cyc++;
    if (s.im || s.dm) begin
      e.ctrl = E_FREEZE;
      m_freeze++;
    end else if (owed > 0) begin
      e.ctrl = E_STALL;
      owed--;
      m_stall++;
    end else begin
      need = 0;
      if (s.ex_memread && (dep(s.ex_rd, s.rs1, s.rs1_use) || dep(s.ex_rd, s.rs2, s.rs2_use)))
        need = 1;
      if (s.br && s.mem_memread && (dep(s.mem_rd, s.rs1, s.rs1_use) || dep(s.mem_rd, s.rs2, s.rs2_use)))
        need = 1;
      if (s.br && s.ex_regwrite && (dep(s.ex_rd, s.rs1, s.rs1_use) || dep(s.ex_rd, s.rs2, s.rs2_use)))
        need = s.ex_memread ? 2 : ((need > 1) ? need : 1);
      if (need > 0) begin
        e.ctrl = E_STALL;
        owed = need - 1;
        m_stall++;
      end else if (s.redirect) begin
        e.ctrl = E_REDIR;
        m_flush++;
      end else begin
        e.ctrl = E_NORMAL;
      end
    end
    if (s.clr) begin
      m_cyc = 0; m_stall = 0; m_freeze = 0; m_flush = 0;
    end
    m_cyc &= MASK; m_stall &= MASK; m_freeze &= MASK; m_flush &= MASK;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int cyc, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a control word; compare mid-cycle.
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = {pc_write, ifid_write, idex_write, exmem_write, memwb_write, ifid_flush, idex_flush};
        check({e.tag, ".ctrl"}, e.cyc, int'(act), int'(e.ctrl));
        if (e.cnt_valid) begin
          check({e.tag, ".cyc_cnt"},    e.cyc, int'(cyc_cnt),    e.c_cyc);
          check({e.tag, ".stall_cnt"},  e.cyc, int'(stall_cnt),  e.c_stall);
          check({e.tag, ".freeze_cnt"}, e.cyc, int'(freeze_cnt), e.c_freeze);
          check({e.tag, ".flush_cnt"},  e.cyc, int'(flush_cnt),  e.c_flush);
        end
      end
    end
  end

  function automatic stim_t rnd(input bit allow_rst);
    stim_t s;
    s.rst         = allow_rst && ($urandom_range(0, 99) == 0);
    s.rs1         = 5'($urandom_range(0, 3));
    s.rs2         = 5'($urandom_range(0, 3));
    s.rs1_use     = 1'($urandom_range(0, 1));
    s.rs2_use     = 1'($urandom_range(0, 1));
    s.br          = ($urandom_range(0, 9) < 4);
    s.redirect    = ($urandom_range(0, 9) < 3);
    s.ex_rd       = 5'($urandom_range(0, 3));
    s.ex_regwrite = 1'($urandom_range(0, 1));
    s.ex_memread  = ($urandom_range(0, 9) < 3);
    s.mem_rd      = 5'($urandom_range(0, 3));
    s.mem_memread = ($urandom_range(0, 9) < 3);
    s.im          = ($urandom_range(0, 9) == 0);
    s.dm          = ($urandom_range(0, 11) == 0);
    s.clr         = allow_rst && ($urandom_range(0, 149) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    rst = 1'b1;
    {id_rs1, id_rs2, ex_rd, mem_rd} = '0;
    {id_rs1_use, id_rs2_use, id_branch_or_jalr, id_redirect} = '0;
    {ex_regwrite, ex_memread, mem_memread, im_stall, dm_stall, perf_clr} = '0;

    s = idle(); s.rst = 1; drive(s, "reset");
    drive(s, "reset2");
    s = idle(); drive(s, "idle");

    s = idle(); s.ex_memread = 1; s.ex_rd = 5; s.rs1 = 5; s.rs1_use = 1;
    drive(s, "load_use");
    s = idle(); drive(s, "load_use_after");

    s = idle(); s.br = 1; s.ex_regwrite = 1; s.ex_rd = 7; s.rs2 = 7; s.rs2_use = 1;
    drive(s, "br_alu");
    s = idle(); drive(s, "br_alu_after");

    s = idle(); s.br = 1; s.ex_regwrite = 1; s.ex_memread = 1; s.ex_rd = 7; s.rs2 = 7; s.rs2_use = 1;
    drive(s, "br_load1");
    s = idle(); s.br = 1; s.rs2 = 7; s.rs2_use = 1; s.mem_rd = 7; s.mem_memread = 1;
    drive(s, "br_load2");
    s = idle(); s.br = 1; s.rs2 = 7; s.rs2_use = 1;
    drive(s, "br_load_done");

    // Freeze arriving in the middle of a two-bubble stall extends it.
    s = idle(); s.br = 1; s.ex_regwrite = 1; s.ex_memread = 1; s.ex_rd = 3; s.rs1 = 3; s.rs1_use = 1;
    drive(s, "br_load_frz1");
    s = idle(); s.im = 1; s.dm = 1; drive(s, "mid_stall_freeze");
    s = idle(); s.dm = 1; drive(s, "mid_stall_freeze2");
    s = idle(); drive(s, "stall2_after_freeze");
    drive(s, "run_after_freeze");

    for (int i = 0; i < 3; i++) begin
      s = idle(); s.redirect = 1; s.im = 1; drive(s, "redir_frozen");
    end
    s = idle(); s.redirect = 1; drive(s, "redir_accept");
    s = idle(); drive(s, "redir_after");

    s = idle(); s.ex_rd = 0; s.ex_regwrite = 1; s.ex_memread = 1; s.br = 1;
    s.rs1_use = 1; s.rs2_use = 1; s.mem_memread = 1; s.mem_rd = 0;
    drive(s, "x0_no_stall");

    s = idle(); s.redirect = 1; s.ex_memread = 1; s.ex_rd = 2; s.rs2 = 2; s.rs2_use = 1;
    drive(s, "redir_vs_hazard");

    s = idle(); s.br = 1; s.ex_regwrite = 1; s.ex_memread = 1; s.ex_rd = 9; s.rs1 = 9; s.rs1_use = 1;
    drive(s, "pre_reset_stall");
    s = idle(); s.rst = 1; drive(s, "reset_in_stall2");
    s = idle(); s.clr = 1; s.ex_memread = 1; s.ex_rd = 4; s.rs1 = 4; s.rs1_use = 1;
    drive(s, "clr_with_stall");
    s = idle(); drive(s, "after_clr");

    for (int i = 0; i < 400; i++) drive(rnd(1'b0), "rand_norst");
    for (int i = 0; i < 800; i++) drive(rnd(1'b1), "rand");

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
